// File: rtl/counter_checker_pkg.sv
// Shared definitions for the sequence counter and its receive-side checker:
// the index-to-value table, checker FSM encoding and error tally limits.
package counter_checker_pkg;

    localparam int unsigned SEQ_LEN = 8;

    // Index i carries the odd value 2*i+1; entry 0 sits in the low nibble.
    localparam logic [SEQ_LEN-1:0][3:0] SEQ_TABLE = {
        4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd1
    };

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCK    = 2'd2
    } state_e;

    localparam int unsigned        ERR_W   = 8;
    localparam logic [ERR_W-1:0]   ERR_MAX = '1;

    // Sequence successor; the 3-bit width gives the 7 -> 0 wrap for free.
    function automatic logic [2:0] idx_next(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/counter_checker_seq_decode.sv
// Inverse of the counter's index-to-value decoder: maps a sampled value back
// to its sequence index and flags values that are not in the table.
module counter_checker_seq_decode
    import counter_checker_pkg::*;
(
    input  logic [3:0] data_i,
    output logic       legal_o,
    output logic [2:0] idx_o
);

    // Table search; at most one entry can match since the table is injective.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves
        // it unassigned, which would otherwise infer a latch.
        legal_o = 1'b0;
        idx_o   = 3'd0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (data_i == SEQ_TABLE[i[2:0]]) begin
                legal_o = 1'b1;
                idx_o   = i[2:0];
            end
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Receive-side sequence monitor: decodes each sampled counter value, locks onto
// the successor order and reports out-of-order samples while locked.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             Valid,
    input  logic             Load,
    input  logic [3:0]       Data_in,
    input  logic             Err_clr,
    output logic             Locked,
    output logic             Error,
    output logic [2:0]       Index,
    output logic [ERR_W-1:0] Err_count
);

    localparam logic [2:0] LOCK_CNT = 3'(LOCK_COUNT);
    localparam logic [2:0] MISS_LIM = 3'(MISS_LIMIT);

    logic       legal;
    logic [2:0] idx;

    state_e           state_q,   state_d;
    logic [2:0]       exp_q,     exp_d;
    logic [2:0]       run_q,     run_d;
    logic [2:0]       miss_q,    miss_d;
    logic [2:0]       index_q,   index_d;
    logic             error_q,   error_d;
    logic             locked_q,  locked_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    counter_checker_seq_decode u_seq_decode (
        .data_i  (Data_in),
        .legal_o (legal),
        .idx_o   (idx)
    );

    // Next-state logic: acquisition, lock tracking, error tally and its clear.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        run_d     = run_q;
        miss_d    = miss_q;
        index_d   = index_q;
        error_d   = 1'b0;
        err_cnt_d = err_cnt_q;

        if (Valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (legal) begin
                        index_d = idx;
                        exp_d   = idx_next(idx);
                        run_d   = 3'd1;
                        miss_d  = 3'd0;
                        state_d = (LOCK_COUNT == 1) ? ST_LOCK : ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (!legal) begin
                        state_d = ST_HUNT;
                    end else begin
                        // In order or not, the run continues from this sample.
                        index_d = idx;
                        exp_d   = idx_next(idx);
                        if (idx == exp_q) begin
                            run_d = run_q + 3'd1;
                            if (run_q + 3'd1 == LOCK_CNT) begin
                                state_d = ST_LOCK;
                                miss_d  = 3'd0;
                            end
                        end else begin
                            run_d = 3'd1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (legal && (idx == exp_q || Load)) begin
                        index_d = idx;
                        exp_d   = idx_next(idx);
                        miss_d  = 3'd0;
                    end else begin
                        // Advance past the bad slot so one corrupted sample
                        // does not desynchronise the expected sequence.
                        error_d = 1'b1;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        exp_d  = idx_next(exp_q);
                        miss_d = miss_q + 3'd1;
                        if (miss_d == MISS_LIM) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (Err_clr) begin
            err_cnt_d = '0;
        end
    end

    assign locked_d = (state_d == ST_LOCK);

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!RST_n) begin
            state_q   <= ST_HUNT;
            exp_q     <= 3'd0;
            run_q     <= 3'd0;
            miss_q    <= 3'd0;
            index_q   <= 3'd0;
            error_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            index_q   <= index_d;
            error_q   <= error_d;
            locked_q  <= locked_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Locked    = locked_q;
    assign Error     = error_q;
    assign Index     = index_q;
    assign Err_count = err_cnt_q;

endmodule

// File: tb/tb_counter_checker.sv
// Randomised and directed bench for counter_checker against a behavioural
// model of the sequence-tracking rules.
module tb_counter_checker;

    localparam int LC = 2;
    localparam int ML = 2;

    localparam int M_HUNT = 0;
    localparam int M_CONF = 1;
    localparam int M_LOCK = 2;

    logic       CLK     = 1'b0;
    logic       RST_n   = 1'b0;
    logic       Valid   = 1'b0;
    logic       Load    = 1'b0;
    logic [3:0] Data_in = 4'd0;
    logic       Err_clr = 1'b0;
    logic       Locked;
    logic       Error;
    logic [2:0] Index;
    logic [7:0] Err_count;

    counter_checker #(
        .LOCK_COUNT (LC),
        .MISS_LIMIT (ML)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Valid     (Valid),
        .Load      (Load),
        .Data_in   (Data_in),
        .Err_clr   (Err_clr),
        .Locked    (Locked),
        .Error     (Error),
        .Index     (Index),
        .Err_count (Err_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    int m_mode, m_exp, m_run, m_miss, m_index, m_err, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_HUNT; m_exp = 0; m_run = 0; m_miss = 0;
        m_index = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit v, input bit l, input logic [3:0] d, input bit c);
        int  sidx;
        bit  legal;
        sidx  = int'(d) / 2;
        legal = (int'(d) % 2) == 1;
        m_err = 0;
        if (v) begin
            if (m_mode == M_HUNT) begin
                if (legal) begin
                    m_index = sidx; m_exp = (sidx + 1) % 8; m_run = 1; m_miss = 0;
                    m_mode  = (LC == 1) ? M_LOCK : M_CONF;
                end
            end else if (m_mode == M_CONF) begin
                if (!legal) m_mode = M_HUNT;
                else if (sidx == m_exp) begin
                    m_run++; m_exp = (m_exp + 1) % 8; m_index = sidx;
                    if (m_run == LC) begin m_mode = M_LOCK; m_miss = 0; end
                end else begin
                    m_run = 1; m_exp = (sidx + 1) % 8; m_index = sidx;
                end
            end else begin
                if (legal && (sidx == m_exp || l)) begin
                    m_index = sidx; m_exp = (sidx + 1) % 8; m_miss = 0;
                end else begin
                    m_err = 1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_exp = (m_exp + 1) % 8;
                    m_miss++;
                    if (m_miss == ML) m_mode = M_HUNT;
                end
            end
        end
        if (c) m_cnt = 0;
    endtask

    function automatic logic [3:0] exp_val();
        return 4'(2 * m_exp + 1);
    endfunction

    // One clock: inputs applied at the falling edge, model advanced at the
    // rising edge, returns at the next falling edge.
    task automatic cycle(input bit v, input bit l, input logic [3:0] d, input bit c);
        Valid = v; Load = l; Data_in = d; Err_clr = c;
        @(posedge CLK);
        if (RST_n) model_step(v, l, d, c);
        @(negedge CLK);
    endtask

    task automatic feed(input logic [3:0] d);
        cycle(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic async_reset();
        @(posedge CLK);
        #2;
        RST_n = 1'b0;
        #1;
        check("rst_locked", Locked, 0);
        check("rst_error", Error, 0);
        check("rst_index", Index, 0);
        check("rst_errcnt", Err_count, 0);
        model_reset();
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("m_locked", Locked, (m_mode == M_LOCK) ? 1 : 0);
            check("m_error", Error, m_err);
            check("m_index", Index, m_index);
            check("m_errcnt", Err_count, m_cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrap_vals [4] = '{13, 15, 1, 3};
        int wrap_idx  [4] = '{6, 7, 0, 1};
        int r;
        logic [3:0] d;
        bit v, l, c;

        model_reset();
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        check("init_locked", Locked, 0);
        check("init_error", Error, 0);
        check("init_index", Index, 0);
        check("init_errcnt", Err_count, 0);
        cmp_en = 1'b1;

        // Lock acquisition
        feed(4'd1);  check("acq_locked_1", Locked, 0);
        feed(4'd3);  check("acq_locked_3", Locked, 1);
        feed(4'd5);  check("acq_index_5", Index, 2);
        check("acq_error_5", Error, 0);

        // Single glitch while expecting 7: the bad sample takes 7's slot,
        // so the counter's next value 9 is the expected one.
        feed(4'd9);
        check("glitch_error", Error, 1);
        check("glitch_errcnt", Err_count, 1);
        check("glitch_locked", Locked, 1);
        feed(4'd9);
        check("glitch_recover_err", Error, 0);
        check("glitch_recover_idx", Index, 4);
        // Miss counter must clear on a good sample: miss, good, miss keeps lock.
        feed(4'd0);
        feed(4'd13);
        feed(4'd2);
        check("miss_cleared_locked", Locked, 1);
        feed(4'd1);

        // Wrap-around
        feed(4'd3); feed(4'd5); feed(4'd7); feed(4'd9); feed(4'd11);
        for (int i = 0; i < 4; i++) begin
            feed(4'(wrap_vals[i]));
            check("wrap_index", Index, wrap_idx[i]);
            check("wrap_error", Error, 0);
        end

        // Lock loss: expecting 5, two consecutive mismatches
        feed(4'd2);
        check("loss1_error", Error, 1);
        check("loss1_locked", Locked, 1);
        feed(4'd8);
        check("loss2_error", Error, 1);
        check("loss2_locked", Locked, 0);

        // Illegal sample in HUNT is ignored
        feed(4'd4);
        check("hunt_illegal_err", Error, 0);
        check("hunt_illegal_lock", Locked, 0);
        feed(4'd1);  check("hunt_relock_1", Locked, 0);
        feed(4'd3);  check("hunt_relock_3", Locked, 1);

        // Load resync while expecting 5
        cycle(1'b1, 1'b1, 4'd11, 1'b0);
        check("load_error", Error, 0);
        check("load_index", Index, 5);
        feed(4'd13);
        check("load_next_err", Error, 0);
        check("load_next_idx", Index, 6);
        cycle(1'b1, 1'b1, 4'd6, 1'b0);
        check("load_illegal_err", Error, 1);
        feed(4'd1);

        // Hold for 10 cycles
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
        end
        check("hold_locked", Locked, 1);
        check("hold_index", Index, 0);

        // Asynchronous reset mid-lock, then first sample is a HUNT sample
        async_reset();
        feed(4'd7);
        check("post_rst_locked", Locked, 0);
        feed(4'd9);
        check("post_rst_lock2", Locked, 1);

        // Saturation: alternate mismatch / match 300 times
        for (int i = 0; i < 300; i++) begin
            feed(4'd0);
            feed(exp_val());
        end
        check("sat_errcnt", Err_count, 255);
        check("sat_locked", Locked, 1);
        feed(4'd0);
        check("sat_hold", Err_count, 255);
        feed(exp_val());
        cycle(1'b1, 1'b0, 4'd0, 1'b1);
        check("clr_error", Error, 1);
        check("clr_errcnt", Err_count, 0);
        feed(exp_val());

        // Randomised phase, biased towards in-order samples
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) async_reset();
            v = $urandom_range(0, 9) != 0;
            l = $urandom_range(0, 15) == 0;
            r = $urandom_range(0, 9);
            d = (r < 7) ? exp_val() : 4'($urandom_range(0, 15));
            c = v && ($urandom_range(0, 63) == 0);
            cycle(v, l, d, c);
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
